// File: rtl/spi_flash_writer_if.sv
// Source-memory and SPI byte-engine ports of the flash writer, bundled for the top-level port list.
// Both ports are toggle handshakes: a transfer is pending while req != ack (or spi_req != spi_ack).
// The master flips req only when nothing is pending, and holds a/spi_d stable until ack matches.
// q/spi_q are valid once ack matches req again.
interface spi_flash_writer_if #(
  parameter int a_bits = 14
);
  logic              req;
  logic              ack;
  logic [a_bits-1:0] a;
  logic [7:0]        q;
  logic              cs_n;
  logic              spi_req;
  logic              spi_ack;
  logic [7:0]        spi_d;
  logic [7:0]        spi_q;

  modport master (
    output req, a, cs_n, spi_req, spi_d,
    input  ack, q, spi_ack, spi_q
  );

  modport slave (
    input  req, a, cs_n, spi_req, spi_d,
    output ack, q, spi_ack, spi_q
  );
endinterface

// File: rtl/spi_flash_writer.sv
// Streams bytes from a local source into SPI NOR flash: WREN, optional 4K sector erase,
// page program split on 256-byte boundaries, and RDSR polling of WIP after every erase/program.
module spi_flash_writer #(
  parameter int a_bits        = 14,
  parameter int cs_high_ticks = 8,
  parameter int poll_limit    = 2000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              erase,
  input  logic [23:0]       flash_addr,
  input  logic [a_bits-1:0] src_addr,
  input  logic [15:0]       amount,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [3:0]        dbg_state,
  spi_flash_writer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_PAGE, S_WREN, S_ERASE, S_PROG, S_DATA, S_POLL, S_GAP, S_DONE
  } state_t;

  localparam logic [23:0] POLL_LIM = 24'(poll_limit);
  localparam logic [15:0] GAP_LAST = 16'(cs_high_ticks - 1);

  state_t            state, gap_next, after_wren, after_poll;
  logic [23:0]       fa;
  logic [a_bits-1:0] sa;
  logic [15:0]       rem;
  logic              erase_l, first;
  logic [2:0]        idx;
  logic [23:0]       poll_cnt;
  logic [15:0]       gap_cnt;
  logic [8:0]        page_left, fetch_left;
  logic [7:0]        buf_q;
  logic              buf_valid, fetch_out;
  logic              req_r, cs_r, spi_req_r;
  logic [a_bits-1:0] a_r;
  logic [7:0]        spi_d_r;
  logic [7:0]        cmd_byte;
  logic [2:0]        cmd_len;
  logic              spi_busy, fetch_en;
  logic [8:0]        page_room, page_len;

  assign bus.req     = req_r;
  assign bus.a       = a_r;
  assign bus.cs_n    = cs_r;
  assign bus.spi_req = spi_req_r;
  assign bus.spi_d   = spi_d_r;
  assign dbg_state   = state;

  assign spi_busy  = spi_req_r != bus.spi_ack;
  // Bytes left before the flash page wraps; a program command never crosses that boundary.
  assign page_room = 9'd256 - {1'b0, fa[7:0]};
  assign page_len  = (rem < {7'd0, page_room}) ? rem[8:0] : page_room;
  // Source fetches overlap the command header and the data bytes, one byte of lookahead.
  assign fetch_en  = (state == S_PROG && idx != 3'd0) || state == S_DATA;

  always_comb begin
    cmd_byte = 8'h00;
    cmd_len  = 3'd4;
    case (state)
      S_WREN: begin
        cmd_byte = 8'h06;
        cmd_len  = 3'd1;
      end
      S_ERASE, S_PROG: begin
        case (idx)
          3'd0:    cmd_byte = (state == S_ERASE) ? 8'h20 : 8'h02;
          3'd1:    cmd_byte = fa[23:16];
          3'd2:    cmd_byte = fa[15:8];
          default: cmd_byte = fa[7:0];
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      gap_next   <= S_IDLE;
      after_wren <= S_PROG;
      after_poll <= S_PAGE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      fa         <= '0;
      sa         <= '0;
      rem        <= '0;
      erase_l    <= 1'b0;
      first      <= 1'b0;
      idx        <= '0;
      poll_cnt   <= '0;
      gap_cnt    <= '0;
      page_left  <= '0;
      fetch_left <= '0;
      buf_q      <= '0;
      buf_valid  <= 1'b0;
      fetch_out  <= 1'b0;
      req_r      <= 1'b0;
      cs_r       <= 1'b1;
      spi_req_r  <= 1'b0;
      a_r        <= '0;
      spi_d_r    <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !done) begin
            error   <= 1'b0;
            fa      <= flash_addr;
            sa      <= src_addr;
            rem     <= amount;
            erase_l <= erase;
            first   <= 1'b1;
            if (amount == 16'd0) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= S_PAGE;
            end
          end
        end
        S_PAGE: begin
          if (rem == 16'd0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx        <= '0;
            state      <= S_WREN;
            after_wren <= (erase_l && (first || fa[11:0] == 12'd0)) ? S_ERASE : S_PROG;
          end
        end
        S_WREN, S_ERASE, S_PROG: begin
          if (!spi_busy) begin
            if (idx < cmd_len) begin
              if (state == S_PROG && idx == 3'd0) begin
                page_left  <= page_len;
                fetch_left <= page_len;
                first      <= 1'b0;
              end
              cs_r      <= 1'b0;
              spi_d_r   <= cmd_byte;
              spi_req_r <= ~spi_req_r;
              idx       <= idx + 3'd1;
            end else begin
              idx <= '0;
              if (state == S_PROG) begin
                state <= S_DATA;
              end else begin
                cs_r    <= 1'b1;
                gap_cnt <= '0;
                state   <= S_GAP;
                if (state == S_WREN) begin
                  gap_next <= after_wren;
                end else begin
                  gap_next   <= S_POLL;
                  after_poll <= S_WREN;
                  after_wren <= S_PROG;
                end
              end
            end
          end
        end
        S_DATA: begin
          if (!spi_busy) begin
            if (page_left == 9'd0) begin
              cs_r       <= 1'b1;
              gap_cnt    <= '0;
              gap_next   <= S_POLL;
              after_poll <= S_PAGE;
              state      <= S_GAP;
            end else if (buf_valid) begin
              spi_d_r   <= buf_q;
              spi_req_r <= ~spi_req_r;
              buf_valid <= 1'b0;
              fa        <= fa + 24'd1;
              rem       <= rem - 16'd1;
              page_left <= page_left - 9'd1;
            end
          end
        end
        S_POLL: begin
          if (!spi_busy) begin
            if (idx == 3'd0) begin
              cs_r      <= 1'b0;
              spi_d_r   <= 8'h05;
              spi_req_r <= ~spi_req_r;
              poll_cnt  <= '0;
              idx       <= 3'd1;
            end else if (idx == 3'd1) begin
              spi_d_r   <= 8'h00;
              spi_req_r <= ~spi_req_r;
              idx       <= 3'd2;
            end else if (!bus.spi_q[0]) begin
              cs_r     <= 1'b1;
              gap_cnt  <= '0;
              gap_next <= after_poll;
              state    <= S_GAP;
              idx      <= '0;
            end else if (poll_cnt + 24'd1 >= POLL_LIM) begin
              // Flash never finished: give up on the rest of the stream.
              error    <= 1'b1;
              cs_r     <= 1'b1;
              gap_cnt  <= '0;
              gap_next <= S_DONE;
              state    <= S_GAP;
              idx      <= '0;
            end else begin
              poll_cnt  <= poll_cnt + 24'd1;
              spi_d_r   <= 8'h00;
              spi_req_r <= ~spi_req_r;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= gap_next;
            if (gap_next == S_DONE) done <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // buf_valid is only ever set here while empty, so the DATA consume above never collides.
      if (fetch_out) begin
        if (bus.ack == req_r) begin
          buf_q     <= bus.q;
          buf_valid <= 1'b1;
          fetch_out <= 1'b0;
          sa        <= sa + a_bits'(1);
        end
      end else if (fetch_en && !buf_valid && fetch_left != 9'd0) begin
        a_r        <= sa;
        req_r      <= ~req_r;
        fetch_out  <= 1'b1;
        fetch_left <= fetch_left - 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_writer.sv
// Bench for spi_flash_writer: source BRAM, SPI engine and W25Q-like flash models, with an
// expected-token queue for the SPI byte/cs stream checked by an independent monitor.
module tb_spi_flash_writer;
  localparam int AB  = 14;
  localparam int GAP = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        erase = 1'b0;
  logic [23:0] flash_addr = '0;
  logic [13:0] src_addr = '0;
  logic [15:0] amount = '0;
  logic        busy, done, error;
  logic [3:0]  dbg_state;

  spi_flash_writer_if #(.a_bits(AB)) bus ();

  spi_flash_writer #(.a_bits(AB), .cs_high_ticks(GAP), .poll_limit(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .erase(erase),
    .flash_addr(flash_addr), .src_addr(src_addr), .amount(amount),
    .busy(busy), .done(done), .error(error), .dbg_state(dbg_state), .bus(bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  logic [8:0] exp_q[$];
  bit  mon_off = 1'b0;
  bit  wip_stuck = 1'b0;
  int  bytes_seen = 0;

  function automatic logic [7:0] src_byte(input logic [13:0] ad);
    return ad[7:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- source BRAM model (0-3 cycle ack delay) ----------------
  logic       ack_m;
  logic [7:0] q_m;
  int         sdly;
  assign bus.ack = ack_m;
  assign bus.q   = q_m;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_m <= 1'b0; q_m <= 8'h00; sdly <= 0;
    end else if (bus.req != ack_m) begin
      if (sdly == 0) begin
        ack_m <= bus.req;
        q_m   <= src_byte(bus.a);
        sdly  <= $urandom_range(0, 3);
      end else begin
        sdly <= sdly - 1;
      end
    end
  end

  // ---------------- SPI engine + flash model ----------------
  logic       sack_m, cs_q;
  logic [7:0] sq_m, op;
  int         pdly, fidx, wip_cnt;
  assign bus.spi_ack = sack_m;
  assign bus.spi_q   = sq_m;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sack_m <= 1'b0; sq_m <= 8'h00; pdly <= 0; fidx <= 0; wip_cnt <= 0;
      op <= 8'h00; cs_q <= 1'b1;
    end else begin
      cs_q <= bus.cs_n;
      if (bus.cs_n) fidx <= 0;
      if (bus.cs_n && !cs_q && (op == 8'h02 || op == 8'h20)) wip_cnt <= 3;
      if (bus.spi_req != sack_m) begin
        if (pdly == 0) pdly <= $urandom_range(1, 3);
        else if (pdly == 1) begin
          pdly   <= 0;
          sack_m <= bus.spi_req;
          fidx   <= fidx + 1;
          if (fidx == 0) begin
            op   <= bus.spi_d;
            sq_m <= 8'hFF;
          end else if (op == 8'h05) begin
            sq_m <= {7'd0, wip_stuck || wip_cnt != 0};
            if (wip_cnt != 0) wip_cnt <= wip_cnt - 1;
          end else begin
            sq_m <= 8'h00;
          end
        end else pdly <= pdly - 1;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  task automatic pop_cmp(input logic [8:0] got);
    logic [8:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL spi_stream: got unexpected token %0h, expected nothing", got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_miss++;
        $display("FAIL spi_stream: got token %0h expected %0h", got, e);
      end
    end
  endtask

  logic prev_sreq = 1'b0;
  logic prev_cs = 1'b1;
  int   gap_cycles = 1000;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_sreq = 1'b0;
      prev_cs   = 1'b1;
      gap_cycles = 0;
    end else begin
      if (bus.spi_req != prev_sreq) begin
        bytes_seen++;
        if (!mon_off) pop_cmp({1'b0, bus.spi_d});
      end
      if (bus.cs_n && !prev_cs && !mon_off) pop_cmp(9'h100);
      if (bus.cs_n) gap_cycles++;
      else begin
        if (prev_cs) chk("cs_gap", gap_cycles >= GAP, 1);
        gap_cycles = 0;
      end
      prev_sreq = bus.spi_req;
      prev_cs   = bus.cs_n;
    end
  end

  // ---------------- expectation helpers ----------------
  task automatic eb(input logic [7:0] b);
    exp_q.push_back({1'b0, b});
  endtask
  task automatic erise();
    exp_q.push_back(9'h100);
  endtask
  task automatic exp_poll(input int n);
    eb(8'h05);
    repeat (n) eb(8'h00);
    erise();
  endtask
  task automatic exp_wren();
    eb(8'h06);
    erise();
  endtask
  task automatic exp_erase(input logic [23:0] fa);
    exp_wren();
    eb(8'h20); eb(fa[23:16]); eb(fa[15:8]); eb(fa[7:0]);
    erise();
    exp_poll(4);
  endtask
  task automatic exp_prog(input logic [23:0] fa, input logic [13:0] sa, input int n);
    logic [13:0] s;
    exp_wren();
    eb(8'h02); eb(fa[23:16]); eb(fa[15:8]); eb(fa[7:0]);
    for (int i = 0; i < n; i++) begin
      s = sa + 14'(i);
      eb(src_byte(s));
    end
    erise();
    exp_poll(4);
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [23:0] fa, input logic [13:0] sa,
                             input logic [15:0] amt, input logic er);
    @(posedge clk); #1;
    start = 1'b1; flash_addr = fa; src_addr = sa; amount = amt; erase = er;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic exp_err);
    bit seen = 1'b0;
    for (int n = 0; n < 20000 && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    chk({name, "_done"}, seen, 1);
    if (seen) begin
      chk({name, "_busy_at_done"}, busy, 1);
      chk({name, "_error"}, error, exp_err);
      chk({name, "_cs_idle"}, bus.cs_n, 1);
      chk({name, "_stream_left"}, exp_q.size(), 0);
      @(negedge clk);
      chk({name, "_busy_after"}, busy, 0);
      chk({name, "_done_pulse"}, done, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_req", bus.req, 0);
    chk("rst_a", bus.a, 0);
    chk("rst_cs_n", bus.cs_n, 1);
    chk("rst_spi_req", bus.spi_req, 0);
    chk("rst_spi_d", bus.spi_d, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);

    // T1: single page; a second start while busy must be ignored
    exp_prog(24'h010000, 14'h0000, 4);
    pulse_start(24'h010000, 14'h0000, 16'd4, 1'b0);
    chk("t1_busy_after_start", busy, 1);
    repeat (20) @(posedge clk);
    pulse_start(24'h0ABCDE, 14'h0100, 16'd9, 1'b1);
    wait_done("t1", 1'b0);

    // T2: page split at 0x100
    exp_prog(24'h0000FE, 14'h0010, 2);
    exp_prog(24'h000100, 14'h0012, 2);
    pulse_start(24'h0000FE, 14'h0010, 16'd4, 1'b0);
    wait_done("t2", 1'b0);

    // flash address wraps 0xFFFFFF -> 0
    exp_prog(24'hFFFFFF, 14'h0100, 1);
    exp_prog(24'h000000, 14'h0101, 1);
    pulse_start(24'hFFFFFF, 14'h0100, 16'd2, 1'b0);
    wait_done("t2w", 1'b0);

    // T3: erase mid-sector, then again at next sector; source address wraps
    exp_erase(24'h000FFF);
    exp_prog(24'h000FFF, 14'h3FFF, 1);
    exp_erase(24'h001000);
    exp_prog(24'h001000, 14'h0000, 1);
    pulse_start(24'h000FFF, 14'h3FFF, 16'd2, 1'b1);
    wait_done("t3", 1'b0);

    // T4: WIP stuck -> 16 polls, error, second page skipped
    wip_stuck = 1'b1;
    exp_wren();
    eb(8'h02); eb(8'h00); eb(8'h00); eb(8'hFF);
    eb(src_byte(14'h0020));
    erise();
    exp_poll(16);
    pulse_start(24'h0000FF, 14'h0020, 16'd3, 1'b0);
    wait_done("t4", 1'b1);
    wip_stuck = 1'b0;

    // T5: amount 0 -> done next cycle, no busy, clears error
    pulse_start(24'h123456, 14'h0000, 16'd0, 1'b0);
    chk("t5_done", done, 1);
    chk("t5_busy", busy, 0);
    chk("t5_error_cleared", error, 0);
    @(posedge clk); #1;
    chk("t5_done_pulse", done, 0);
    chk("t5_busy_after", busy, 0);
    chk("t5_cs_n", bus.cs_n, 1);
    repeat (10) @(posedge clk);
    chk("t5_stream_left", exp_q.size(), 0);

    // T6: reset during data phase, then a fresh operation
    mon_off = 1'b1;
    begin
      int base;
      bit reached = 1'b0;
      base = bytes_seen;
      pulse_start(24'h030000, 14'h0040, 16'd8, 1'b0);
      for (int n = 0; n < 3000 && !reached; n++) begin
        @(negedge clk);
        reached = (bytes_seen >= base + 8);
      end
      chk("t6_reach_data", reached, 1);
    end
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    chk("t6_cs_n", bus.cs_n, 1);
    chk("t6_busy", busy, 0);
    chk("t6_req", bus.req, 0);
    chk("t6_spi_req", bus.spi_req, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_q.delete();
    mon_off = 1'b0;
    repeat (12) @(posedge clk);
    exp_prog(24'h040000, 14'h0005, 2);
    pulse_start(24'h040000, 14'h0005, 16'd2, 1'b0);
    wait_done("t6", 1'b0);

    repeat (5) @(posedge clk);
    chk("final_stream_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
